// File: rtl/truth_tbl_pkg.sv
// Shared definitions for the truth-table checker: FSM state encoding and
// the width of the per-vector settle counter.
package truth_tbl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_settle_counter.sv
// Per-vector dwell timer: reloads with SETTLE and counts down while enabled,
// flagging the cycle in which the current vector must be sampled.
module tt_settle_counter
    import truth_tbl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_sample_now
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero       = (r_cnt == '0);
    assign o_sample_now = w_zero;

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge values of its neighbours regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en) begin
            // Reload on the sampling cycle so the next vector gets a full dwell.
            r_cnt <= w_zero ? LOAD_VAL : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Walks a combinational DUT through every input vector, records its output
// per vector and compares the captured table against a latched golden table.
module truth_table_checker
    import truth_tbl_pkg::*;
#(
    parameter int VARS   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<VARS)-1:0]   expected,
    output logic [VARS-1:0]        vec_out,
    input  logic                   y_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<VARS)-1:0]   captured,
    output logic [VARS:0]          mismatch_count,
    output logic [VARS-1:0]        first_fail_idx,
    output logic                   first_fail_valid
);

    localparam int DEPTH = 1 << VARS;

    state_t             r_state;
    logic [DEPTH-1:0]   r_expected;

    logic               w_accept;
    logic               w_sample_now;
    logic               w_last;
    logic               w_mismatch;
    logic [VARS:0]      w_next_count;

    assign w_accept     = start && (r_state != RUN);
    assign w_last       = &vec_out;
    assign w_mismatch   = (y_in != r_expected[vec_out]);
    // Count including the sample taken this edge, so pass sees the final vector.
    assign w_next_count = mismatch_count + (VARS+1)'(w_mismatch);

    tt_settle_counter #(
        .SETTLE       (SETTLE)
    ) u_settle (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_accept),
        .i_en         (r_state == RUN),
        .o_sample_now (w_sample_now)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_expected       <= '0;
            vec_out          <= '0;
            captured         <= '0;
            mismatch_count   <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state          <= RUN;
                        r_expected       <= expected;
                        vec_out          <= '0;
                        captured         <= '0;
                        mismatch_count   <= '0;
                        first_fail_idx   <= '0;
                        first_fail_valid <= 1'b0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_sample_now) begin
                        captured[vec_out] <= y_in;
                        if (w_mismatch) begin
                            mismatch_count <= w_next_count;
                            if (!first_fail_valid) begin
                                first_fail_idx   <= vec_out;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_next_count == '0);
                        end else begin
                            vec_out <= vec_out + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response-side counterpart to the exhaustive vector stimulus used for the combinational expression labs.
- Steps a combinational DUT through all 2**VARS input vectors, MSB = first variable.
- Captures the DUT output per vector and compares the captured truth table against an expected table.
- Reports pass/fail, mismatch count and first failing index; synthesizable, so it works on-board as well as in simulation.

Parameters:
- VARS, 3, number of DUT inputs (1..6); table depth is 2**VARS.
- SETTLE, 1, extra cycles each vector is held before sampling (0..15); each vector occupies SETTLE+1 cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- expected  in  2**VARS  golden table, bit i = expected y for vector i; latched on accepted start
- vec_out  out  VARS  vector driven to the DUT inputs
- y_in  in  1  DUT output
- busy  out  1  high while in RUN
- done  out  1  high in DONE until the next accepted start or reset
- pass  out  1  valid when done=1; 1 iff mismatch_count==0
- captured  out  2**VARS  captured truth table, bit i = sampled y for vector i
- mismatch_count  out  VARS+1  number of vectors with captured != expected
- first_fail_idx  out  VARS  lowest failing vector index
- first_fail_valid  out  1  at least one mismatch recorded this run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; outputs vec_out, captured, mismatch_count, first_fail_idx, first_fail_valid, busy, done, pass all 0.
  - Internal expected latch and settle counter are also cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge:
  - latch expected; clear captured, mismatch_count and first_fail_*; clear done and pass.
  - set vec_out=0 and cnt=0; go to RUN.
- RUN, each edge:
  - If cnt!=SETTLE: cnt<=cnt+1.
  - If cnt==SETTLE: captured[vec_out]<=y_in. On mismatch, mismatch_count increments; if first_fail_valid=0, set first_fail_idx=vec_out and first_fail_valid=1.
  - Then, if vec_out==2**VARS-1: go to DONE, set done=1, and set pass from the final mismatch count, including this sample.
  - Otherwise: vec_out<=vec_out+1, cnt<=0.
- Latency:
  - Vector k is sampled at edge (k+1)*(SETTLE+1) after the start edge.
  - done rises at edge 2**VARS*(SETTLE+1); for VARS=3, SETTLE=1 that is edge 16.
- vec_out holds the last vector (2**VARS-1) in DONE.
- captured and the other results hold stable in DONE.
- start while in RUN is ignored; the run is neither restarted nor extended.
- start held high continuously: a new run begins on the first edge in DONE, so runs go back-to-back with done high for exactly one cycle.
- rst_n low mid-run aborts immediately to reset values; partial results are discarded.
- expected changing during RUN has no effect; only the latched copy is used.
- mismatch_count saturation is not needed; its width covers 2**VARS.
- SETTLE=0: one cycle per vector, sampled at the end of the cycle in which it is driven.

Decomposition:
- Package truth_tbl_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a CNT_W=4 constant for the settle counter.
- One sub-module, tt_settle_counter: a parameterized down-counter/comparator producing sample_now.
- The FSM, capture and compare logic stay in the top module.

Test Plan:
- DUT y=(a&b)|c, expected=8'hEA, SETTLE=1, pulse start → done at edge 16, captured=8'hEA, pass=1, mismatch_count=0, first_fail_valid=0.
- Same DUT, expected=8'hEB → pass=0, mismatch_count=1, first_fail_idx=0, first_fail_valid=1.
- y_in tied 0, expected=8'hEA → captured=8'h00, mismatch_count=5, first_fail_idx=1.
- Pulse start again at edge 6 of a run → ignored, done still at edge 16; then start with start held high → next run begins on the edge after done rises, and done is high for one cycle.
- rst_n low for 1 cycle while vec_out=3 → all outputs 0 immediately, state IDLE; a later start gives a full correct run.
- SETTLE=0 with VARS=2, DUT y=a^b, expected=4'h6 → vec_out steps 0,1,2,3 on consecutive cycles, done at edge 4, pass=1.
